// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// byte-count helper used for lane masks and crossing detection.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and shifted store data for the
// selected word of a (possibly two-word) access, and load merge/shift/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  logic [7:0]  base_mask;
  logic [7:0]  mask;
  logic [4:0]  sh;
  logic [63:0] wd64;
  logic [31:0] raw;

  always_comb begin
    sh         = {off, 3'b000};
    base_mask  = (8'h01 << size_bytes(size)) - 8'h01;
    mask       = base_mask << off;
    wd64       = {32'b0, wdata} << sh;
    sel        = hi ? mask[7:4] : mask[3:0];
    wdata_lane = hi ? wd64[63:32] : wd64[31:0];
    // Upper word only contributes when the access crosses into it.
    raw        = 32'({rd_hi, rd_lo} >> sh);
    case (size)
      SZ_B:    rdata = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    rdata = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a word-addressed RAM with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to support unaligned and word-crossing accesses.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_str,
  output logic              mem_ld,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              lat_we;
  logic              lat_uns;
  logic [1:0]        lat_size;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       buf0;
  logic [ADDR_W-1:0] word_lo;
  logic              in_acc1;
  logic              access;
  logic              req_bad;
  logic [31:0]       rd_lo;
  logic [31:0]       rd_hi;
  logic [3:0]        lane_sel;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  assign word_lo   = lat_addr[ADDR_W+1:2];
  assign in_acc1   = (state == ST_ACC1);
  assign access    = (state == ST_ACC0) || in_acc1;
  assign req_ready = (state == ST_IDLE);

  always_comb begin
    req_bad = (req_size == SZ_X);
`ifndef LSU_MISALIGN_SPLIT_EN
    if (req_size == SZ_H && req_addr[0])
      req_bad = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00)
      req_bad = 1'b1;
`endif
  end

  // The word being read this cycle bypasses its buffer so the response can
  // be registered on the closing edge of the last access.
  assign rd_lo = (state == ST_ACC0) ? mem_rdata : buf0;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] buf1;
  logic        crossing;
  assign rd_hi    = in_acc1 ? mem_rdata : buf1;
  assign crossing = ({1'b0, lat_addr[1:0]} + size_bytes(lat_size)) > 3'd4;
`else
  assign rd_hi = 32'b0;
`endif

  lsu_lane_align u_align (
    .size       (lat_size),
    .uns        (lat_uns),
    .off        (lat_addr[1:0]),
    .hi         (in_acc1),
    .wdata      (lat_wdata),
    .rd_lo      (rd_lo),
    .rd_hi      (rd_hi),
    .sel        (lane_sel),
    .wdata_lane (lane_wdata),
    .rdata      (lane_rdata)
  );

  assign mem_str   = access && lat_we;
  assign mem_ld    = access && !lat_we;
  assign mem_sel   = access ? lane_sel : 4'b0;
  assign mem_addr  = access ? (in_acc1 ? word_lo + ADDR_W'(1) : word_lo) : '0;
  assign mem_wdata = mem_str ? lane_wdata : 32'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= SZ_B;
      lat_addr  <= '0;
      lat_wdata <= 32'b0;
      buf0      <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      buf1      <= 32'b0;
`endif
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (req_bad) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state <= ST_ACC0;
            end
          end
        end
        ST_ACC0: begin
          buf0 <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (crossing) begin
            state <= ST_ACC1;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= lat_we ? 32'b0 : lane_rdata;
          end
`else
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= lat_we ? 32'b0 : lane_rdata;
`endif
        end
        ST_ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          buf1 <= mem_rdata;
`endif
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= lat_we ? 32'b0 : lane_rdata;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
